acc_stack: RTL and testbench
============================

// Module: acc_stack
// PURPOSE
//  Next-generation accumulator: W-bit acc register with a DEPTH-entry save/restore stack,
//  nibble-sliced immediate loading generalised to any W (multiple of 4), and encoded ops.
//  Sits between the register file / ALU and the datapath operand bus; the decoder drives Op.
// PARAMETERS
//  W      8  acc/stack data width; multiple of 4, >= 8
//  DEPTH  4  stack entries; >= 2
//  SW     $clog2(W/4) (derived, localparam) width of Slice; W=8 gives SW=1
// PORTS
//  clk       in   1      clock; all state updates on posedge
//  Reset     in   1      synchronous, active-high; clears all state
//  Write_En  in   1      Op valid this cycle; 0 = hold all state
//  Op        in   3      0 NOP,1 LD_REG,2 LD_ALU,3 LD_IMM,4 CLR,5 PUSH,6 POP,7 SWAP
//  RegInput  in   W      load source for LD_REG
//  ALUInput  in   W      load source for LD_ALU
//  Imm_in    in   4      nibble for LD_IMM
//  Slice     in   SW     nibble index for LD_IMM (0 = bits[3:0])
//  Err_Clr   in   1      clears sticky Err (only with ACC_STK_ERR_EN)
//  DataOut   out  W      current acc value (registered)
//  TopOut    out  W      stack top entry; 0 when empty
//  Count     out  $clog2(DEPTH+1)  occupied entries
//  Full      out  1      Count == DEPTH
//  Empty     out  1      Count == 0
//  Err       out  1      sticky stack-misuse flag
// BEHAVIOUR
//  - Reset: acc=0, Count=0, all stack entries=0, Err=0; Reset beats Write_En/Op/Err_Clr.
//  - Reset mid-sequence discards stack contents; first op after Reset deasserts sees empty stack.
//  - All ops single-cycle; result visible on DataOut/TopOut/Count the cycle after the edge.
//  - Write_En=0 or Op=NOP: no state change.
//  - LD_REG/LD_ALU: acc <= source. CLR: acc <= 0. Stack untouched.
//  - LD_IMM: acc[4*Slice+3 : 4*Slice] <= Imm_in, other bits held. Slice >= W/4 (non-pow2 W):
//    no-op, flagged as misuse.
//  - PUSH: stack[Count] <= acc, Count+1; acc unchanged. If Full: no change, misuse.
//  - POP: acc <= stack[Count-1], Count-1. If Empty: no change, misuse.
//  - SWAP: acc <-> stack[Count-1] in same edge, Count unchanged. If Empty: no change, misuse.
//  - TopOut = stack[Count-1] combinationally from registered state; 0 when Empty.
//  - Full/Empty combinational from Count; never both high.
//  - Undefined Op encodings: none (3-bit space fully decoded).
// CONFIGURATION
//  ACC_STK_ERR_EN defined: misuse (PUSH on Full, POP/SWAP on Empty, bad Slice) sets Err next
//    cycle; Err holds until Err_Clr or Reset; misuse and Err_Clr in same cycle -> Err=1.
//  ACC_STK_ERR_EN undefined: Err tied 0, Err_Clr ignored; misuse ops still no-ops.
// TESTING
//  1 W=8: LD_IMM Slice0 Imm 4'hA, then Slice1 Imm 4'h5 -> DataOut 8'h0A, then 8'h5A.
//  2 LD_REG 8'h11 PUSH, LD_REG 8'h22 PUSH, LD_ALU 8'h33, POP -> DataOut 8'h22, Count 1, TopOut 8'h11.
//  3 DEPTH=4: 4 PUSH -> Full=1; 5th PUSH -> Count 4, stack unchanged, Err=1 (ERR_EN) / 0 (not).
//  4 Empty: POP and SWAP -> DataOut unchanged, Count 0, Err=1; Err_Clr -> Err=0 next cycle.
//  5 acc 8'hAB, top 8'hCD, SWAP -> DataOut 8'hCD, TopOut 8'hAB, Count unchanged.
//  6 Count=3, Reset with Write_En=1 Op=PUSH -> DataOut 0, Count 0, Empty 1, Err 0.

Source files
------------

// File: rtl/acc_stack_if.sv
// acc_stack_if: operand/control bundle between the decoder (master) and the
// accumulator stack (slave). Carries the op strobe, load sources, nibble
// immediate, error clear, and the registered acc/stack status back.
// Ports: Write_En/Op/RegInput/ALUInput/Imm_in/Slice/Err_Clr (master->slave),
//        DataOut/TopOut/Count/Full/Empty/Err (slave->master).
interface acc_stack_if #(
  parameter int W     = 8,
  parameter int DEPTH = 4
);
  localparam int SW = $clog2(W / 4);
  localparam int CW = $clog2(DEPTH + 1);

  logic          Write_En;
  logic [2:0]    Op;
  logic [W-1:0]  RegInput;
  logic [W-1:0]  ALUInput;
  logic [3:0]    Imm_in;
  logic [SW-1:0] Slice;
  logic          Err_Clr;

  logic [W-1:0]  DataOut;
  logic [W-1:0]  TopOut;
  logic [CW-1:0] Count;
  logic          Full;
  logic          Empty;
  logic          Err;

  modport master (
    output Write_En, Op, RegInput, ALUInput, Imm_in, Slice, Err_Clr,
    input  DataOut, TopOut, Count, Full, Empty, Err
  );

  modport slave (
    input  Write_En, Op, RegInput, ALUInput, Imm_in, Slice, Err_Clr,
    output DataOut, TopOut, Count, Full, Empty, Err
  );
endinterface

// File: rtl/acc_stack.sv
// acc_stack: W-bit accumulator with a DEPTH-entry save/restore stack and
// nibble-sliced immediate loads; ops decoded from a 3-bit Op code.
// Latency: every op commits on one clk edge; results visible the next cycle.
// Backpressure: none; misuse ops (PUSH on full, POP/SWAP on empty, bad Slice)
// are dropped as no-ops.
// Ports: clk, Reset (sync, active-high), bus (acc_stack_if.slave).
// Build option: define ACC_STK_ERR_EN to enable the sticky Err flag and
// Err_Clr; otherwise Err is tied low and Err_Clr is ignored.
module acc_stack #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         Reset,
  acc_stack_if.slave   bus
);
  localparam int SW  = $clog2(W / 4);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int NSL = W / 4;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_LD_REG = 3'd1;
  localparam logic [2:0] OP_LD_ALU = 3'd2;
  localparam logic [2:0] OP_LD_IMM = 3'd3;
  localparam logic [2:0] OP_CLR    = 3'd4;
  localparam logic [2:0] OP_PUSH   = 3'd5;
  localparam logic [2:0] OP_POP    = 3'd6;
  localparam logic [2:0] OP_SWAP   = 3'd7;

  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  stk_q [DEPTH];
  logic [W-1:0]  stk_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  top;
  logic          full, empty;
  logic          misuse;
  int            slice_idx;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  // Top-of-stack mux; compares against Count rather than indexing so the
  // Count width never has to match the array index width.
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cnt_q == CW'(i + 1)) top = stk_q[i];
    end
  end

  always_comb begin
    acc_d     = acc_q;
    stk_d     = stk_q;
    cnt_d     = cnt_q;
    misuse    = 1'b0;
    slice_idx = int'(bus.Slice);
    if (bus.Write_En) begin
      case (bus.Op)
        OP_NOP:    ;
        OP_LD_REG: acc_d = bus.RegInput;
        OP_LD_ALU: acc_d = bus.ALUInput;
        OP_LD_IMM: begin
          // Slice can exceed the nibble count only when W/4 is not a power of 2.
          if (slice_idx < NSL) begin
            for (int i = 0; i < NSL; i++) begin
              if (slice_idx == i) acc_d[4*i +: 4] = bus.Imm_in;
            end
          end else begin
            misuse = 1'b1;
          end
        end
        OP_CLR:    acc_d = '0;
        OP_PUSH: begin
          if (full) begin
            misuse = 1'b1;
          end else begin
            for (int i = 0; i < DEPTH; i++) begin
              if (cnt_q == CW'(i)) stk_d[i] = acc_q;
            end
            cnt_d = cnt_q + CW'(1);
          end
        end
        OP_POP: begin
          if (empty) begin
            misuse = 1'b1;
          end else begin
            acc_d = top;
            cnt_d = cnt_q - CW'(1);
          end
        end
        OP_SWAP: begin
          if (empty) begin
            misuse = 1'b1;
          end else begin
            acc_d = top;
            for (int i = 0; i < DEPTH; i++) begin
              if (cnt_q == CW'(i + 1)) stk_d[i] = acc_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      acc_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      stk_q <= stk_d;
    end
  end

`ifdef ACC_STK_ERR_EN
  logic err_q, err_d;

  // Misuse wins over a same-cycle clear so no error event is ever lost.
  always_comb begin
    err_d = err_q;
    if (bus.Err_Clr) err_d = 1'b0;
    if (misuse)      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (Reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign bus.Err = err_q;
`else
  logic unused_err;
  assign unused_err = bus.Err_Clr | misuse;
  assign bus.Err    = 1'b0;
`endif

  assign bus.DataOut = acc_q;
  assign bus.TopOut  = top;
  assign bus.Count   = cnt_q;
  assign bus.Full    = full;
  assign bus.Empty   = empty;
endmodule

// File: tb/tb_acc_stack.sv
// tb_acc_stack: directed bench for acc_stack (W=8, DEPTH=4). Each step
// pushes the expected post-edge state into a queue; the state is popped and
// compared one cycle later, plus directed constant checks on key results.
module tb_acc_stack;
  localparam int W     = 8;
  localparam int DEPTH = 4;
`ifdef ACC_STK_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] t;
    logic [2:0] c;
    logic       f;
    logic       e;
    logic       err;
  } exp_t;

  logic clk   = 1'b0;
  logic Reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  exp_t       exp_q [$];
  logic [7:0] m_acc;
  logic [7:0] m_stk [$];
  logic       m_err;

  acc_stack_if #(.W(W), .DEPTH(DEPTH)) bus ();
  acc_stack #(.W(W), .DEPTH(DEPTH)) dut (.clk(clk), .Reset(Reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, update the reference model, queue the
  // expected state, then compare against the DUT after the edge.
  task automatic step(input string tag, input bit rst, input bit we, input logic [2:0] op,
                      input logic [7:0] rv, input logic [7:0] av, input logic [3:0] imm,
                      input logic sl, input bit ec);
    bit   mis;
    exp_t e, got;
    logic [7:0] tmp;
    @(negedge clk);
    Reset        = rst;
    bus.Write_En = we;
    bus.Op       = op;
    bus.RegInput = rv;
    bus.ALUInput = av;
    bus.Imm_in   = imm;
    bus.Slice    = sl;
    bus.Err_Clr  = ec;
    mis = 1'b0;
    if (rst) begin
      m_acc = 8'h00;
      m_stk.delete();
      m_err = 1'b0;
    end else begin
      if (we) begin
        case (op)
          3'd1: m_acc = rv;
          3'd2: m_acc = av;
          3'd3: if (sl) m_acc[7:4] = imm; else m_acc[3:0] = imm;
          3'd4: m_acc = 8'h00;
          3'd5: if (m_stk.size() == DEPTH) mis = 1'b1; else m_stk.push_back(m_acc);
          3'd6: if (m_stk.size() == 0) mis = 1'b1; else m_acc = m_stk.pop_back();
          3'd7: if (m_stk.size() == 0) mis = 1'b1;
                else begin
                  tmp = m_stk[$];
                  m_stk[$] = m_acc;
                  m_acc = tmp;
                end
          default: ;
        endcase
      end
      if (ERR_ON) begin
        if (ec)  m_err = 1'b0;
        if (mis) m_err = 1'b1;
      end
    end
    e.d   = m_acc;
    e.t   = (m_stk.size() != 0) ? m_stk[$] : 8'h00;
    e.c   = 3'(m_stk.size());
    e.f   = (m_stk.size() == DEPTH);
    e.e   = (m_stk.size() == 0);
    e.err = m_err;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      got = exp_q.pop_front();
      check({tag, ".DataOut"}, 32'(bus.DataOut), 32'(got.d));
      check({tag, ".TopOut"},  32'(bus.TopOut),  32'(got.t));
      check({tag, ".Count"},   32'(bus.Count),   32'(got.c));
      check({tag, ".Full"},    32'(bus.Full),    32'(got.f));
      check({tag, ".Empty"},   32'(bus.Empty),   32'(got.e));
      check({tag, ".Err"},     32'(bus.Err),     32'(got.err));
    end
  endtask

  task automatic op(input string tag, input logic [2:0] o, input logic [7:0] v);
    step(tag, 1'b0, 1'b1, o, v, v, v[3:0], v[4], 1'b0);
  endtask

  initial begin
    bus.Write_En = 1'b0; bus.Op = 3'd0; bus.RegInput = '0; bus.ALUInput = '0;
    bus.Imm_in = '0; bus.Slice = '0; bus.Err_Clr = 1'b0;
    m_acc = 8'h00; m_err = 1'b0;

    // Reset state
    step("rst0", 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0);
    step("rst1", 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0);
    check("rst_data", 32'(bus.DataOut), 32'h00);
    check("rst_empty", 32'(bus.Empty), 32'h1);

    // 1: nibble immediates
    step("imm0", 1'b0, 1'b1, 3'd3, 8'h00, 8'h00, 4'hA, 1'b0, 1'b0);
    check("t1_lo", 32'(bus.DataOut), 32'h0A);
    step("imm1", 1'b0, 1'b1, 3'd3, 8'h00, 8'h00, 4'h5, 1'b1, 1'b0);
    check("t1_hi", 32'(bus.DataOut), 32'h5A);

    // 2: push/pop sequence
    step("ldr11", 1'b0, 1'b1, 3'd1, 8'h11, 8'hEE, 4'h0, 1'b0, 1'b0);
    op("push1", 3'd5, 8'h00);
    step("ldr22", 1'b0, 1'b1, 3'd1, 8'h22, 8'hEE, 4'h0, 1'b0, 1'b0);
    op("push2", 3'd5, 8'h00);
    step("lda33", 1'b0, 1'b1, 3'd2, 8'hEE, 8'h33, 4'h0, 1'b0, 1'b0);
    op("pop1", 3'd6, 8'h00);
    check("t2_data", 32'(bus.DataOut), 32'h22);
    check("t2_count", 32'(bus.Count), 32'd1);
    check("t2_top", 32'(bus.TopOut), 32'h11);

    // Hold: Write_En low and NOP leave state alone
    step("hold_we0", 1'b0, 1'b0, 3'd1, 8'hFF, 8'hFF, 4'hF, 1'b1, 1'b0);
    op("hold_nop", 3'd0, 8'hFF);

    // 3: fill to Full, overflow push
    step("rst3", 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      op("fill_ld", 3'd1, 8'(i));
      op("fill_push", 3'd5, 8'h00);
    end
    check("t3_full", 32'(bus.Full), 32'h1);
    op("ovf_ld", 3'd1, 8'h99);
    op("ovf_push", 3'd5, 8'h00);
    check("t3_count", 32'(bus.Count), 32'd4);
    check("t3_top", 32'(bus.TopOut), 32'h04);
    check("t3_err", 32'(bus.Err), 32'(ERR_ON));
    step("errclr3", 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1);
    check("t3_errclr", 32'(bus.Err), 32'h0);
    for (int i = 0; i < 4; i++) op("drain", 3'd6, 8'h00);
    check("t3_drain", 32'(bus.DataOut), 32'h01);

    // 4: misuse on empty
    op("pop_empty", 3'd6, 8'h00);
    check("t4_pop_data", 32'(bus.DataOut), 32'h01);
    op("swap_empty", 3'd7, 8'h00);
    check("t4_swap_cnt", 32'(bus.Count), 32'd0);
    check("t4_err", 32'(bus.Err), 32'(ERR_ON));
    step("errclr4", 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1);
    check("t4_errclr", 32'(bus.Err), 32'h0);
    step("mis_clr", 1'b0, 1'b1, 3'd6, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1);
    check("t4_mis_wins", 32'(bus.Err), 32'(ERR_ON));

    // 5: swap
    op("ldCD", 3'd1, 8'hCD);
    op("pushCD", 3'd5, 8'h00);
    op("ldAB", 3'd1, 8'hAB);
    op("swap", 3'd7, 8'h00);
    check("t5_data", 32'(bus.DataOut), 32'hCD);
    check("t5_top", 32'(bus.TopOut), 32'hAB);
    check("t5_count", 32'(bus.Count), 32'd1);

    // 6: reset beats a concurrent push
    op("push_a", 3'd5, 8'h00);
    op("push_b", 3'd5, 8'h00);
    check("t6_pre", 32'(bus.Count), 32'd3);
    step("rst_push", 1'b1, 1'b1, 3'd5, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0);
    check("t6_data", 32'(bus.DataOut), 32'h00);
    check("t6_count", 32'(bus.Count), 32'd0);
    check("t6_empty", 32'(bus.Empty), 32'h1);
    check("t6_err", 32'(bus.Err), 32'h0);

    // CLR and first op after reset sees an empty stack
    op("ld77", 3'd1, 8'h77);
    op("clr", 3'd4, 8'h00);
    check("clr_data", 32'(bus.DataOut), 32'h00);
    op("pop_post_rst", 3'd6, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
